// File: rtl/mac_streamer_gen.sv
// Multi-channel TCDM streamer: NIN strided read channels feeding FIFO streams and one
// strided write channel draining a stream FIFO, all sequenced by a small global FSM.
module mac_streamer_gen #(
  parameter int unsigned NIN = 3,
  parameter int unsigned FD  = 4,
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 32,
  parameter int unsigned LW  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     enable_i,
  input  logic                     start_i,
  input  logic [(NIN+1)*AW-1:0]    base_i,
  input  logic [(NIN+1)*AW-1:0]    stride_i,
  input  logic [(NIN+1)*LW-1:0]    len_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [NIN-1:0]           in_valid_o,
  input  logic [NIN-1:0]           in_ready_i,
  output logic [NIN*DW-1:0]        in_data_o,
  input  logic                     out_valid_i,
  output logic                     out_ready_o,
  input  logic [DW-1:0]            out_data_i,
  output logic [NIN:0]             tcdm_req_o,
  input  logic [NIN:0]             tcdm_gnt_i,
  output logic [(NIN+1)*AW-1:0]    tcdm_add_o,
  output logic [NIN:0]             tcdm_wen_o,
  output logic [(NIN+1)*DW/8-1:0]  tcdm_be_o,
  output logic [(NIN+1)*DW-1:0]    tcdm_data_o,
  input  logic [(NIN+1)*DW-1:0]    tcdm_r_data_i,
  input  logic [NIN:0]             tcdm_r_valid_i
);
  localparam int unsigned PW = $clog2(FD);
  localparam logic [PW:0] FdOcc = (PW+1)'(FD);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  state_e state;

  logic           run, start_acc, all_done;
  logic [NIN:0]   fin;
  logic [NIN-1:0] rempty;

  assign run       = (state == StRun);
  assign start_acc = (state == StIdle) & start_i;
  assign all_done  = (&fin) & (&rempty);

  assign tcdm_wen_o = {1'b0, {NIN{1'b1}}};
  assign tcdm_be_o  = '1;

  // The write channel never receives read responses.
  logic unused_wr_resp;
  assign unused_wr_resp = ^{tcdm_r_valid_i[NIN], tcdm_r_data_i[NIN*DW +: DW]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= StIdle;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else if (clear_i) begin
      state  <= StIdle;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      unique case (state)
        StIdle: if (start_i) begin
          state  <= StRun;
          busy_o <= 1'b1;
        end
        StRun: if (all_done) begin
          state  <= StDone;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        StDone: begin
          state  <= StIdle;
          done_o <= 1'b0;
        end
        default: begin
          state  <= StIdle;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NIN; c++) begin : g_rd
    logic [AW-1:0]   addr, stride;
    logic [LW-1:0]   cnt;
    logic            outst, held, req, gnt, push, pop;
    logic [DW-1:0]   mem [FD];
    logic [PW-1:0]   wp, rp;
    logic [PW:0]     occ;
    logic [PW+1:0]   fill;

    // A slot is reserved for every in-flight read so the FIFO can never overflow.
    assign fill = {1'b0, occ} + {{(PW+1){1'b0}}, outst};
    assign req  = ~clear_i & (held | (run & (cnt != '0) & enable_i & (fill < {1'b0, FdOcc})));
    assign gnt  = req & tcdm_gnt_i[c];
    assign push = tcdm_r_valid_i[c] & outst;
    assign pop  = (occ != '0) & in_ready_i[c];

    assign tcdm_req_o[c]              = req;
    assign tcdm_add_o[c*AW +: AW]     = addr;
    assign tcdm_data_o[c*DW +: DW]    = '0;
    assign in_valid_o[c]              = (occ != '0);
    assign in_data_o[c*DW +: DW]      = mem[rp];
    assign fin[c]                     = (cnt == '0) & ~outst;
    assign rempty[c]                  = (occ == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        addr <= '0; stride <= '0; cnt <= '0; outst <= 1'b0; held <= 1'b0;
        wp <= '0; rp <= '0; occ <= '0;
      end else if (clear_i) begin
        addr <= '0; stride <= '0; cnt <= '0; outst <= 1'b0; held <= 1'b0;
        wp <= '0; rp <= '0; occ <= '0;
      end else begin
        if (start_acc) begin
          addr   <= base_i[c*AW +: AW];
          stride <= stride_i[c*AW +: AW];
          cnt    <= len_i[c*LW +: LW];
        end else if (gnt) begin
          addr <= addr + stride;
          cnt  <= cnt - 1'b1;
        end
        if (gnt) outst <= 1'b1;
        else if (tcdm_r_valid_i[c]) outst <= 1'b0;
        held <= req & ~tcdm_gnt_i[c];
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        if (push && !pop) occ <= occ + 1'b1;
        else if (pop && !push) occ <= occ - 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) mem[wp] <= tcdm_r_data_i[c*DW +: DW];
    end
  end

  logic [AW-1:0] waddr, wstride;
  logic [LW-1:0] wcnt, wlen, wacc;
  logic          wheld, wreq, wpush, wpop;
  logic [DW-1:0] wmem [FD];
  logic [PW-1:0] wwp, wrp;
  logic [PW:0]   wocc;

  assign out_ready_o = run & ~clear_i & (wocc != FdOcc) & (wacc < wlen);
  assign wpush       = out_valid_i & out_ready_o;
  assign wreq        = ~clear_i & (wheld | (run & (wocc != '0) & (wcnt != '0) & enable_i));
  assign wpop        = wreq & tcdm_gnt_i[NIN];

  assign tcdm_req_o[NIN]          = wreq;
  assign tcdm_add_o[NIN*AW +: AW] = waddr;
  assign tcdm_data_o[NIN*DW +: DW] = (wocc != '0) ? wmem[wrp] : '0;
  assign fin[NIN]                 = (wcnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      waddr <= '0; wstride <= '0; wcnt <= '0; wlen <= '0; wacc <= '0; wheld <= 1'b0;
      wwp <= '0; wrp <= '0; wocc <= '0;
    end else if (clear_i) begin
      waddr <= '0; wstride <= '0; wcnt <= '0; wlen <= '0; wacc <= '0; wheld <= 1'b0;
      wwp <= '0; wrp <= '0; wocc <= '0;
    end else begin
      if (start_acc) begin
        waddr   <= base_i[NIN*AW +: AW];
        wstride <= stride_i[NIN*AW +: AW];
        wcnt    <= len_i[NIN*LW +: LW];
        wlen    <= len_i[NIN*LW +: LW];
        wacc    <= '0;
      end else begin
        if (wpop) begin
          waddr <= waddr + wstride;
          wcnt  <= wcnt - 1'b1;
        end
        if (wpush) wacc <= wacc + 1'b1;
      end
      wheld <= wreq & ~tcdm_gnt_i[NIN];
      if (wpush) wwp <= wwp + 1'b1;
      if (wpop) wrp <= wrp + 1'b1;
      if (wpush && !wpop) wocc <= wocc + 1'b1;
      else if (wpop && !wpush) wocc <= wocc - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wpush) wmem[wwp] <= out_data_i;
  end

endmodule
